// File: rtl/jtag_master_pkg.sv
// Shared types for the JTAG master.
//   cmd_type_e : command encoding on cmd_type (3 is reserved and behaves as TAP_RESET)
//   state_e    : scan sequencer states
//   head_t     : TMS preamble walked before the shift phase (or the whole TAP_RESET)
package jtag_master_pkg;

  localparam int MAX_LEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    CMD_TAP_RESET = 2'd0,
    CMD_IR_SCAN   = 2'd1,
    CMD_DR_SCAN   = 2'd2,
    CMD_RESERVED  = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TAIL  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // tms holds the preamble LSB first; last is the index of its final TCK.
  typedef struct packed {
    logic [5:0] tms;
    logic [2:0] last;
    logic       to_shift;
  } head_t;

  function automatic head_t head_seq(input cmd_type_e t);
    head_t h;
    case (t)
      CMD_IR_SCAN: h = '{tms: 6'b000011, last: 3'd3, to_shift: 1'b1}; // 1,1,0,0
      CMD_DR_SCAN: h = '{tms: 6'b000001, last: 3'd2, to_shift: 1'b1}; // 1,0,0
      default:     h = '{tms: 6'b011111, last: 3'd5, to_shift: 1'b0}; // 1,1,1,1,1,0
    endcase
    return h;
  endfunction

endpackage

// File: rtl/jtag_if.sv
// JTAG pin bundle. The master drives trst_n/tck/tms/tdi and samples tdo.
interface jtag_if;
  logic trst_n;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;

  modport master (output trst_n, tck, tms, tdi, input tdo);
  modport target (input trst_n, tck, tms, tdi, output tdo);
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK generator: while en is high, tck is low CLK_DIV clk cycles then high
// CLK_DIV clk cycles. rise_stb/fall_stb flag the clk edge on which tck
// toggles, so the sequencer can act on exactly that edge.
//   clk, rst  : clock, async active-high reset
//   en        : run; when low tck is parked low and the divider restarts
//   tck       : divided clock
//   rise_stb  : tck rises on this clk edge
//   fall_stb  : tck falls on this clk edge
module jtag_tck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] div_q;
  logic       tck_q;
  logic       wrap;

  assign wrap     = en && (div_q == 8'(CLK_DIV - 1));
  assign rise_stb = wrap && !tck_q;
  assign fall_stb = wrap && tck_q;
  assign tck      = tck_q;

  // NOTE: asynchronous reset so tck drops the instant rst rises; state uses <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else if (!en) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else if (wrap) begin
      div_q <= '0;
      tck_q <= !tck_q;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

endmodule

// File: rtl/jtag_master.sv
// Command-driven JTAG scan master.
//   clk, rst           : clock, async active-high reset
//   cmd_valid/ready    : command handshake; ready only in IDLE
//   cmd_type           : TAP_RESET / IR_SCAN / DR_SCAN (3 = TAP_RESET)
//   cmd_len            : shift length minus one
//   cmd_data           : TDI bits, LSB shifted first
//   rsp_valid/ready    : result handshake; result held until consumed
//   rsp_data           : captured TDO bits, bit i = i-th sampled bit
//   jtag               : JTAG pins (master side)
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  jtag_if.master             jtag
);

  localparam int IDX_W = $clog2(MAX_LEN);

  state_e             state_q, state_d;
  logic [6:0]         cnt_q, cnt_d;      // TCK index within the current phase
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               trst_n_q;
  logic [MAX_LEN-1:0] data_q, data_d;    // remaining TDI bits, shifted right
  logic [MAX_LEN-1:0] cap_q, cap_d;      // captured TDO bits
  logic [5:0]         len_q, len_d;
  head_t              head_q, head_d;

  logic tck_w, rise_stb, fall_stb, tck_en;

  assign tck_en = (state_q == ST_HEAD) || (state_q == ST_SHIFT) || (state_q == ST_TAIL);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (tck_en),
    .tck      (tck_w),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign jtag.tck    = tck_w;
  assign jtag.tms    = tms_q;
  assign jtag.tdi    = tdi_q;
  assign jtag.trst_n = trst_n_q;

  // trst_n_q doubles as "out of reset for at least one clk".
  assign cmd_ready = (state_q == ST_IDLE) && trst_n_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = cap_q;

  // NOTE: every next-state variable takes its hold value first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    data_d  = data_q;
    cap_d   = cap_q;
    len_d   = len_q;
    head_d  = head_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          head_d  = head_seq(cmd_type_e'(cmd_type));
          state_d = ST_HEAD;
          cnt_d   = '0;
          tms_d   = head_d.tms[0];
          tdi_d   = 1'b0;
          data_d  = cmd_data;
          len_d   = cmd_len;
          cap_d   = '0;
        end
      end

      ST_HEAD: begin
        if (fall_stb) begin
          if (cnt_q[2:0] == head_q.last) begin
            cnt_d = '0;
            if (head_q.to_shift) begin
              state_d = ST_SHIFT;
              tms_d   = (len_q == 6'd0);     // single-bit scan exits on its only bit
              tdi_d   = data_q[0];
            end else begin
              state_d = ST_RESP;
            end
          end else begin
            cnt_d = cnt_q + 7'd1;
            tms_d = head_q.tms[cnt_q[2:0] + 3'd1];
          end
        end
      end

      ST_SHIFT: begin
        if (rise_stb) cap_d[cnt_q[IDX_W-1:0]] = jtag.tdo;
        if (fall_stb) begin
          if (cnt_q == {1'b0, len_q}) begin
            state_d = ST_TAIL;
            cnt_d   = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            cnt_d  = cnt_q + 7'd1;
            data_d = data_q >> 1;
            tdi_d  = data_q[1];
            tms_d  = ((cnt_q + 7'd1) == {1'b0, len_q});
          end
        end
      end

      ST_TAIL: begin
        // Exit1 -> Update (tms=1) -> Run-Test/Idle (tms=0)
        if (fall_stb) begin
          if (cnt_q[0]) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + 7'd1;
            tms_d = 1'b0;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      trst_n_q <= 1'b0;
      data_q   <= '0;
      cap_q    <= '0;
      len_q    <= '0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      trst_n_q <= 1'b1;
      data_q   <= data_d;
      cap_q    <= cap_d;
      len_q    <= len_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Self-checking bench for jtag_master: loopback scans, a TAP model with an
// IDCODE register, mid-scan reset and response back-pressure.
module tb_jtag_master;
  import jtag_master_pkg::*;

  localparam int          CLK_DIV = 2;
  localparam int          MAX_LEN = 64;
  localparam logic [31:0] IDCODE  = 32'hDEB11001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [63:0] cmd_data = '0;
  logic        rsp_ready = 1'b1;
  logic        loopback = 1'b1;
  logic        cmd_ready, rsp_valid;
  logic [63:0] rsp_data;

  jtag_if jif ();

  jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .jtag      (jif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TCK monitor: TMS value at every rising TCK
  int   tck_total = 0;
  logic tms_hist [0:1023];
  always @(posedge jif.tck) begin
    if (tck_total < 1024) tms_hist[tck_total] <= jif.tms;
    tck_total <= tck_total + 1;
  end

  // TAP controller model with a 32-bit IDCODE data register
  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7,
                 UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;
  int          tap_st = TLR;
  logic [31:0] dr_sh;

  function automatic int tap_next(input int s, input logic tms);
    case (s)
      TLR:     return tms ? TLR  : RTI;
      RTI:     return tms ? SDR  : RTI;
      SDR:     return tms ? SIR  : CDR;
      CDR:     return tms ? E1DR : SHDR;
      SHDR:    return tms ? E1DR : SHDR;
      E1DR:    return tms ? UDR  : PDR;
      PDR:     return tms ? E2DR : PDR;
      E2DR:    return tms ? UDR  : SHDR;
      UDR:     return tms ? SDR  : RTI;
      SIR:     return tms ? TLR  : CIR;
      CIR:     return tms ? E1IR : SHIR;
      SHIR:    return tms ? E1IR : SHIR;
      E1IR:    return tms ? UIR  : PIR;
      PIR:     return tms ? E2IR : PIR;
      E2IR:    return tms ? UIR  : SHIR;
      default: return tms ? SDR  : RTI;
    endcase
  endfunction

  always @(posedge jif.tck or negedge jif.trst_n) begin
    if (!jif.trst_n) begin
      tap_st <= TLR;
      dr_sh  <= '0;
    end else begin
      if (tap_st == CDR)       dr_sh <= IDCODE;
      else if (tap_st == SHDR) dr_sh <= {jif.tdi, dr_sh[31:1]};
      tap_st <= tap_next(tap_st, jif.tms);
    end
  end

  assign jif.tdo = loopback ? jif.tdi : ((tap_st == SHDR) ? dr_sh[0] : 1'b0);

  // Scoreboard and counters
  logic [63:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int acc_cyc = 0;
  int tck_start = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected TMS stream (LSB = first TCK) and TCK count for a command.
  function automatic void exp_tms(input int typ, input int n, output logic [127:0] v, output int cnt);
    v = '0;
    cnt = 0;
    if (typ == 0 || typ == 3) begin
      for (int i = 0; i < 6; i++) v[i] = (i < 5);
      cnt = 6;
      return;
    end
    if (typ == 1) begin v[0] = 1'b1; v[1] = 1'b1; cnt = 4; end
    else begin v[0] = 1'b1; cnt = 3; end
    for (int i = 0; i < n; i++) begin v[cnt] = (i == n - 1); cnt++; end
    v[cnt] = 1'b1;
    cnt += 2;
  endfunction

  task automatic send_cmd(input logic [1:0] typ, input logic [5:0] len,
                          input logic [63:0] data, input logic [63:0] exp);
    bit rdy;
    rdy = 1'b0;
    for (int i = 0; i < 100 && !rdy; i++) begin @(negedge clk); rdy = cmd_ready; end
    if (!rdy) check("cmd_ready wait", 128'(cmd_ready), 128'(1));
    cmd_type  = typ;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tck_start = tck_total;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    cmd_data  = ~data;     // the DUT must have registered the command
    cmd_type  = ~typ;
    cmd_len   = ~len;
  endtask

  task automatic wait_rsp(input string tag, input int typ, input int n);
    logic [127:0] tv, ov;
    logic [63:0]  exp;
    int           cnt;
    bit           got;
    exp_tms(typ, n, tv, cnt);
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin @(negedge clk); got = rsp_valid; end
    if (!got) begin
      check({tag, " timeout"}, 128'(rsp_valid), 128'(1));
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    check({tag, " latency"}, 128'(cyc - acc_cyc), 128'(2 * CLK_DIV * cnt));
    check({tag, " data"}, 128'(rsp_data), 128'(exp));
    check({tag, " tck count"}, 128'(tck_total - tck_start), 128'(cnt));
    ov = '0;
    for (int i = 0; i < cnt; i++) ov[i] = tms_hist[tck_start + i];
    check({tag, " tms"}, ov, tv);
    check({tag, " tdi idle"}, 128'({jif.tdi, jif.tck}), 128'(0));
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held
    repeat (3) @(negedge clk);
    check("reset pins", 128'({jif.tck, jif.tms, jif.tdi, jif.trst_n}), 128'(4'b0100));
    check("reset handshake", 128'({cmd_ready, rsp_valid, rsp_data}), 128'(0));
    rst = 1'b0;
    #1;
    check("ready before first clk", 128'(cmd_ready), 128'(0));
    @(negedge clk);
    check("release", 128'({jif.trst_n, cmd_ready}), 128'(2'b11));
    repeat (5) @(negedge clk);
    check("no auto reset", 128'(tck_total), 128'(0));

    // Loopback scans
    send_cmd(2'd0, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    wait_rsp("tap_reset", 0, 0);
    send_cmd(2'd2, 6'd7, 64'hA5, 64'hA5);
    wait_rsp("dr8", 2, 8);
    send_cmd(2'd1, 6'd63, 64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567);
    wait_rsp("ir64", 1, 64);
    send_cmd(2'd3, 6'd5, 64'h3F, 64'h0);
    wait_rsp("reserved", 3, 0);
    send_cmd(2'd2, 6'd0, 64'h1, 64'h1);
    wait_rsp("dr1", 2, 1);

    // TAP model: read IDCODE
    loopback = 1'b0;
    send_cmd(2'd0, 6'd0, 64'h0, 64'h0);
    wait_rsp("model reset", 0, 0);
    check("model rti after reset", 128'(tap_st), 128'(RTI));
    send_cmd(2'd2, 6'd31, 64'h0, {32'h0, IDCODE});
    wait_rsp("idcode", 2, 32);
    check("model rti after dr", 128'(tap_st), 128'(RTI));
    loopback = 1'b1;

    // Reset in the middle of a DR scan
    send_cmd(2'd2, 6'd7, 64'hC3, 64'hC3);
    for (int i = 0; i < 200 && (tck_total - tck_start) < 5; i++) @(negedge clk);
    check("reached tck5", 128'((tck_total - tck_start) >= 5), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midscan reset pins", 128'({jif.tck, jif.trst_n, jif.tms, jif.tdi}), 128'(4'b0010));
    check("midscan reset handshake", 128'({rsp_valid, cmd_ready, rsp_data}), 128'(0));
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midscan release", 128'({jif.trst_n, cmd_ready}), 128'(2'b11));
    send_cmd(2'd2, 6'd7, 64'h3C, 64'h3C);
    wait_rsp("after reset", 2, 8);

    // Response back-pressure with a pending command
    rsp_ready = 1'b0;
    send_cmd(2'd2, 6'd15, 64'h1234, 64'h1234);
    wait_rsp("held", 2, 16);
    cmd_type  = 2'd0;
    cmd_len   = 6'd0;
    cmd_data  = '0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold", 128'({rsp_valid, cmd_ready, rsp_data}), {62'h0, 2'b10, 64'h1234});
    end
    rsp_ready = 1'b1;
    tck_start = tck_total;
    exp_q.push_back(64'h0);
    @(posedge clk);
    #1;
    check("handshake to idle", 128'({rsp_valid, cmd_ready}), 128'(2'b01));
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    check("accepted after handshake", 128'(cmd_ready), 128'(0));
    wait_rsp("post-hold reset", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
